// File: rtl/tlb_gen2.sv
// tlb_gen2: fully associative TLB with separate instruction and data lookup ports,
// a probe port, indexed read/write and a sequential ASID invalidation sweep.
module tlb_gen2 #(
    parameter int unsigned TLB_NUM     = 16,
    parameter int unsigned ASID_W      = 8,
    parameter int unsigned PAGEMASK_EN = 1,
    localparam int unsigned IW         = $clog2(TLB_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ASID_W-1:0] asid_i,
    input  logic              inst_req_i,
    input  logic [31:0]       inst_vaddr_i,
    output logic              inst_ack_o,
    output logic [36:0]       inst_bus_o,
    input  logic              data_req_i,
    input  logic [31:0]       data_vaddr_i,
    output logic              data_ack_o,
    output logic [37:0]       data_bus_o,
    input  logic              wr_en_i,
    input  logic [IW-1:0]     wr_idx_i,
    input  logic [127:0]      cp0_bus_i,
    input  logic              probe_en_i,
    output logic              probe_ack_o,
    output logic [31:0]       probe_index_o,
    input  logic [IW-1:0]     rd_idx_i,
    output logic [127:0]      rd_bus_o,
    input  logic              inv_req_i,
    input  logic              inv_mode_i,
    input  logic [ASID_W-1:0] inv_asid_i,
    output logic              busy_o,
    output logic              inv_done_o
);

    typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

    state_e state_q, state_d;
    logic [IW-1:0]     cnt_q, cnt_d;
    logic              inv_mode_q;
    logic [ASID_W-1:0] inv_asid_q;

    logic              e_q        [TLB_NUM];
    logic [18:0]       vpn2_q     [TLB_NUM];
    logic [11:0]       mask_q     [TLB_NUM];
    logic              g_q        [TLB_NUM];
    logic [ASID_W-1:0] ent_asid_q [TLB_NUM];
    logic [19:0]       pfn0_q     [TLB_NUM];
    logic [19:0]       pfn1_q     [TLB_NUM];
    logic [2:0]        c0_q       [TLB_NUM];
    logic [2:0]        c1_q       [TLB_NUM];
    logic              d0_q       [TLB_NUM];
    logic              d1_q       [TLB_NUM];
    logic              v0_q       [TLB_NUM];
    logic              v1_q       [TLB_NUM];

    logic [31:0] cp0_pagemask, cp0_hi, cp0_lo0, cp0_lo1;
    assign cp0_pagemask = cp0_bus_i[31:0];
    assign cp0_hi       = cp0_bus_i[63:32];
    assign cp0_lo0      = cp0_bus_i[95:64];
    assign cp0_lo1      = cp0_bus_i[127:96];

    logic unused_cp0;
    assign unused_cp0 = ^cp0_bus_i;

    function automatic logic ent_match(input int i, input logic [31:0] va,
                                       input logic [ASID_W-1:0] asid);
        logic [18:0] keep;
        keep = ~{7'b0, mask_q[i]};
        return e_q[i] && ((va[31:13] & keep) == (vpn2_q[i] & keep))
               && (g_q[i] || (ent_asid_q[i] == asid));
    endfunction

    // Odd/even page chosen by the address bit just above the masked span.
    function automatic logic page_sel(input logic [31:0] va, input logic [11:0] mask);
        return |(va[24:12] & ({mask, 1'b1} ^ {1'b0, mask}));
    endfunction

    function automatic logic [31:0] phys(input logic [19:0] pfn, input logic [11:0] mask,
                                         input logic [31:0] va);
        return {pfn & ~{8'b0, mask}, 12'h000} | (va & {8'b0, mask, 12'hfff});
    endfunction

    // Result layout {paddr, c, d, v, found}; all matching entries are ORed.
    function automatic logic [37:0] lookup(input logic [31:0] va,
                                           input logic [ASID_W-1:0] asid);
        logic [37:0] res;
        res = '0;
        for (int i = 0; i < int'(TLB_NUM); i++) begin
            if (ent_match(i, va, asid)) begin
                if (page_sel(va, mask_q[i])) begin
                    res = res | {phys(pfn1_q[i], mask_q[i], va), c1_q[i], d1_q[i], v1_q[i], 1'b1};
                end else begin
                    res = res | {phys(pfn0_q[i], mask_q[i], va), c0_q[i], d0_q[i], v0_q[i], 1'b1};
                end
            end
        end
        return res;
    endfunction

    logic [37:0] inst_res, data_res;
    logic [31:0] probe_res;
    logic        idle, wr_go, sweep_clr;

    always_comb begin
        inst_res = lookup(inst_vaddr_i, asid_i);
        data_res = lookup(data_vaddr_i, asid_i);
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        probe_res = 32'h8000_0000;
        for (int i = int'(TLB_NUM) - 1; i >= 0; i--) begin
            if (ent_match(i, cp0_hi, cp0_hi[ASID_W-1:0])) begin
                probe_res = 32'(i);
            end
        end
    end

    assign idle      = (state_q == StIdle);
    assign wr_go     = idle && wr_en_i;
    assign sweep_clr = (state_q == StSweep)
                       && (!inv_mode_q || (!g_q[cnt_q] && (ent_asid_q[cnt_q] == inv_asid_q)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_o     = 1'b0;
        inv_done_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (inv_req_i) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                end
            end
            StSweep: begin
                busy_o = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == IW'(TLB_NUM - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                busy_o     = 1'b1;
                inv_done_o = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            inv_mode_q <= 1'b0;
            inv_asid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (idle && inv_req_i) begin
                inv_mode_q <= inv_mode_i;
                inv_asid_q <= inv_asid_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(TLB_NUM); i++) begin
                e_q[i]        <= 1'b0;
                vpn2_q[i]     <= '0;
                mask_q[i]     <= '0;
                g_q[i]        <= 1'b0;
                ent_asid_q[i] <= '0;
                pfn0_q[i]     <= '0;
                pfn1_q[i]     <= '0;
                c0_q[i]       <= '0;
                c1_q[i]       <= '0;
                d0_q[i]       <= 1'b0;
                d1_q[i]       <= 1'b0;
                v0_q[i]       <= 1'b0;
                v1_q[i]       <= 1'b0;
            end
        end else if (wr_go) begin
            e_q[wr_idx_i]        <= 1'b1;
            vpn2_q[wr_idx_i]     <= cp0_hi[31:13];
            mask_q[wr_idx_i]     <= (PAGEMASK_EN != 0) ? cp0_pagemask[24:13] : 12'h000;
            g_q[wr_idx_i]        <= cp0_lo0[0] & cp0_lo1[0];
            ent_asid_q[wr_idx_i] <= cp0_hi[ASID_W-1:0];
            pfn0_q[wr_idx_i]     <= cp0_lo0[25:6];
            pfn1_q[wr_idx_i]     <= cp0_lo1[25:6];
            c0_q[wr_idx_i]       <= cp0_lo0[5:3];
            c1_q[wr_idx_i]       <= cp0_lo1[5:3];
            d0_q[wr_idx_i]       <= cp0_lo0[2];
            d1_q[wr_idx_i]       <= cp0_lo1[2];
            v0_q[wr_idx_i]       <= cp0_lo0[1];
            v1_q[wr_idx_i]       <= cp0_lo1[1];
        end else if (sweep_clr) begin
            e_q[cnt_q] <= 1'b0;
        end
    end

    // While busy every request is acknowledged as a miss with an all-zero result.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_ack_o    <= 1'b0;
            inst_bus_o    <= '0;
            data_ack_o    <= 1'b0;
            data_bus_o    <= '0;
            probe_ack_o   <= 1'b0;
            probe_index_o <= '0;
            rd_bus_o      <= '0;
        end else begin
            inst_ack_o  <= inst_req_i;
            data_ack_o  <= data_req_i;
            probe_ack_o <= probe_en_i;
            if (inst_req_i) begin
                inst_bus_o <= idle ? {inst_res[37:6], inst_res[5:3], inst_res[1], inst_res[0]}
                                   : 37'h0;
            end
            if (data_req_i) begin
                data_bus_o <= idle ? data_res : 38'h0;
            end
            if (probe_en_i) begin
                probe_index_o <= idle ? probe_res : 32'h8000_0000;
            end
            rd_bus_o <= {6'b0, pfn1_q[rd_idx_i], c1_q[rd_idx_i], d1_q[rd_idx_i], v1_q[rd_idx_i],
                         g_q[rd_idx_i],
                         6'b0, pfn0_q[rd_idx_i], c0_q[rd_idx_i], d0_q[rd_idx_i], v0_q[rd_idx_i],
                         g_q[rd_idx_i],
                         vpn2_q[rd_idx_i], 5'b0, 8'(ent_asid_q[rd_idx_i]),
                         7'b0, mask_q[rd_idx_i], 13'b0};
        end
    end

endmodule

// File: tb/tb_tlb_gen2.sv
// tb_tlb_gen2: directed vector table plus hand-written sweep and reset sequences.
module tb_tlb_gen2;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   asid;
    logic         inst_req, data_req, wr_en, probe_en, inv_req, inv_mode;
    logic [31:0]  inst_vaddr, data_vaddr;
    logic [3:0]   wr_idx, rd_idx;
    logic [127:0] cp0_bus;
    logic [7:0]   inv_asid;
    logic         inst_ack, data_ack, probe_ack, busy, inv_done;
    logic [36:0]  inst_bus;
    logic [37:0]  data_bus;
    logic [31:0]  probe_index;
    logic [127:0] rd_bus;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tlb_gen2 #(.TLB_NUM(16), .ASID_W(8), .PAGEMASK_EN(1)) dut (
        .clk(clk), .rst(rst), .asid_i(asid),
        .inst_req_i(inst_req), .inst_vaddr_i(inst_vaddr), .inst_ack_o(inst_ack),
        .inst_bus_o(inst_bus),
        .data_req_i(data_req), .data_vaddr_i(data_vaddr), .data_ack_o(data_ack),
        .data_bus_o(data_bus),
        .wr_en_i(wr_en), .wr_idx_i(wr_idx), .cp0_bus_i(cp0_bus),
        .probe_en_i(probe_en), .probe_ack_o(probe_ack), .probe_index_o(probe_index),
        .rd_idx_i(rd_idx), .rd_bus_o(rd_bus),
        .inv_req_i(inv_req), .inv_mode_i(inv_mode), .inv_asid_i(inv_asid),
        .busy_o(busy), .inv_done_o(inv_done)
    );

    typedef struct {
        logic         wr;
        logic [3:0]   idx;
        logic [127:0] cp0;
        logic [7:0]   asid;
        logic         iq;
        logic [31:0]  iva;
        logic         dq;
        logic [31:0]  dva;
        logic         pq;
        logic [36:0]  ei;
        logic [37:0]  ed;
        logic [31:0]  ep;
    } vec_t;

    vec_t vt[15];

    function automatic logic [127:0] cp(input logic [31:0] lo1, input logic [31:0] lo0,
                                        input logic [31:0] hi, input logic [31:0] pm);
        return {lo1, lo0, hi, pm};
    endfunction

    function automatic vec_t mkv(input logic wr, input logic [3:0] idx, input logic [127:0] c,
                                 input logic [7:0] a, input logic iq, input logic [31:0] iva,
                                 input logic dq, input logic [31:0] dva, input logic pq,
                                 input logic [36:0] ei, input logic [37:0] ed,
                                 input logic [31:0] ep);
        vec_t v;
        v.wr = wr; v.idx = idx; v.cp0 = c; v.asid = a; v.iq = iq; v.iva = iva;
        v.dq = dq; v.dva = dva; v.pq = pq; v.ei = ei; v.ed = ed; v.ep = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; single-cycle strobes drop after the edge.
    task automatic cyc(input logic wr, input logic [3:0] idx, input logic [127:0] c,
                       input logic [7:0] a, input logic iq, input logic [31:0] iva,
                       input logic dq, input logic [31:0] dva, input logic pq);
        wr_en = wr; wr_idx = idx; cp0_bus = c; asid = a;
        inst_req = iq; inst_vaddr = iva; data_req = dq; data_vaddr = dva; probe_en = pq;
        tick();
        wr_en = 1'b0; inst_req = 1'b0; data_req = 1'b0; probe_en = 1'b0;
    endtask

    task automatic sweep_wait(output int bc, output int dc);
        bc = 0;
        dc = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) bc++;
            if (inv_done) dc++;
            tick();
        end
    endtask

    int bc, dc;

    initial begin
        rst = 1'b1; asid = '0; inst_req = 0; data_req = 0; wr_en = 0; probe_en = 0;
        inv_req = 0; inv_mode = 0; inv_asid = '0; inst_vaddr = '0; data_vaddr = '0;
        wr_idx = '0; rd_idx = '0; cp0_bus = '0;

        vt[0]  = mkv(1, 3, cp(32'h1056, 32'h1016, 32'h0040_0005, 0), 5, 1, 32'h0040_1ABC,
                     0, 0, 0, 37'h0, 38'h0, 0);
        vt[1]  = mkv(0, 0, 0, 5, 1, 32'h0040_1ABC, 1, 32'h0040_0ABC, 0,
                     {32'h0004_1ABC, 3'd2, 1'b1, 1'b1}, {32'h0004_0ABC, 3'd2, 1'b1, 1'b1, 1'b1}, 0);
        vt[2]  = mkv(1, 0, cp(32'h801E, 32'h0, 32'h0100_0005, 32'h6000), 5, 0, 0, 0, 0, 0,
                     0, 0, 0);
        vt[3]  = mkv(0, 0, 0, 5, 1, 32'h0100_3123, 1, 32'h0100_7123, 0,
                     {32'h0000_3123, 3'd0, 1'b0, 1'b1}, {32'h0020_3123, 3'd3, 1'b1, 1'b1, 1'b1}, 0);
        vt[4]  = mkv(0, 0, cp(0, 0, 32'h0040_0006, 0), 5, 0, 0, 0, 0, 1, 0, 0, 32'h8000_0000);
        vt[5]  = mkv(0, 0, cp(0, 0, 32'h0040_0005, 0), 5, 0, 0, 0, 0, 1, 0, 0, 32'd3);
        vt[6]  = mkv(1, 3, cp(32'h1057, 32'h1017, 32'h0040_0006, 0), 5, 0, 0, 0, 0, 1,
                     0, 0, 32'h8000_0000);
        vt[7]  = mkv(0, 0, cp(0, 0, 32'h0040_0006, 0), 5, 0, 0, 0, 0, 1, 0, 0, 32'd3);
        vt[8]  = mkv(0, 0, cp(0, 0, 32'h0100_1005, 0), 5, 0, 0, 0, 0, 1, 0, 0, 32'd0);
        vt[9]  = mkv(0, 0, 0, 5, 1, 32'h0050_0000, 1, 32'h0040_0ABC, 0,
                     37'h0, {32'h0004_0ABC, 3'd2, 1'b1, 1'b1, 1'b1}, 0);
        vt[10] = mkv(1, 1, cp(32'h1057, 32'h1017, 32'h0040_0006, 0), 5, 0, 0, 0, 0, 0,
                     0, 0, 0);
        vt[11] = mkv(0, 0, cp(0, 0, 32'h0040_0006, 0), 5, 1, 32'h0040_1ABC, 0, 0, 1,
                     {32'h0004_1ABC, 3'd2, 1'b1, 1'b1}, 0, 32'd1);
        vt[12] = mkv(1, 6, cp(32'h2056, 32'h2016, 32'h0060_0007, 0), 5, 0, 0, 0, 0, 0,
                     0, 0, 0);
        vt[13] = mkv(0, 0, 0, 5, 1, 32'h0060_0123, 1, 32'h0060_0123, 0, 37'h0, 38'h0, 0);
        vt[14] = mkv(0, 0, 0, 7, 1, 32'h0060_0123, 1, 32'h0060_1123, 0,
                     {32'h0008_0123, 3'd2, 1'b1, 1'b1}, {32'h0008_1123, 3'd2, 1'b1, 1'b1, 1'b1}, 0);

        // Reset state
        tick(); tick();
        chk("rst_inst_ack", 128'(inst_ack), 0);
        chk("rst_inst_bus", 128'(inst_bus), 0);
        chk("rst_data_ack", 128'(data_ack), 0);
        chk("rst_data_bus", 128'(data_bus), 0);
        chk("rst_probe_ack", 128'(probe_ack), 0);
        chk("rst_probe_idx", 128'(probe_index), 0);
        chk("rst_rd_bus", rd_bus, 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_done", 128'(inv_done), 0);
        rst = 1'b0;

        for (int n = 0; n < 15; n++) begin
            cyc(vt[n].wr, vt[n].idx, vt[n].cp0, vt[n].asid, vt[n].iq, vt[n].iva,
                vt[n].dq, vt[n].dva, vt[n].pq);
            chk($sformatf("v%0d_inst_ack", n), 128'(inst_ack), 128'(vt[n].iq));
            chk($sformatf("v%0d_data_ack", n), 128'(data_ack), 128'(vt[n].dq));
            chk($sformatf("v%0d_probe_ack", n), 128'(probe_ack), 128'(vt[n].pq));
            if (vt[n].iq) chk($sformatf("v%0d_inst_bus", n), 128'(inst_bus), 128'(vt[n].ei));
            if (vt[n].dq) chk($sformatf("v%0d_data_bus", n), 128'(data_bus), 128'(vt[n].ed));
            if (vt[n].pq) chk($sformatf("v%0d_probe_idx", n), 128'(probe_index), 128'(vt[n].ep));
        end

        // Read-back rebuild
        rd_idx = 4'd3; tick();
        chk("rd_idx3", rd_bus, cp(32'h1057, 32'h1017, 32'h0040_0006, 0));
        rd_idx = 4'd0; tick();
        chk("rd_idx0", rd_bus, cp(32'h801E, 32'h0, 32'h0100_0005, 32'h6000));

        // Selective sweep: mode/ASID latched at start, requests during busy miss
        rst = 1'b1; tick(); rst = 1'b0;
        cyc(1, 1, cp(32'h1056, 32'h1016, 32'h0010_0005, 0), 5, 0, 0, 0, 0, 0);
        cyc(1, 2, cp(32'h1057, 32'h1017, 32'h0020_0005, 0), 5, 0, 0, 0, 0, 0);
        cyc(1, 4, cp(32'h3056, 32'h3016, 32'h0040_0007, 0), 5, 0, 0, 0, 0, 0);
        inv_mode = 1'b1; inv_asid = 8'd5; inv_req = 1'b1;
        tick();
        inv_req = 1'b0; inv_mode = 1'b0; inv_asid = 8'd7;
        bc = busy ? 1 : 0;
        cyc(1, 5, cp(32'h1057, 32'h1017, 32'h0050_0005, 0), 5, 1, 32'h0010_1ABC, 0, 0, 0);
        chk("busy_inst_ack", 128'(inst_ack), 1);
        chk("busy_inst_bus", 128'(inst_bus), 0);
        begin
            int b2;
            sweep_wait(b2, dc);
            bc += b2;
        end
        chk("sweep_busy_cycles", 128'(bc), 17);
        chk("sweep_done_pulses", 128'(dc), 1);
        cyc(0, 0, 0, 5, 1, 32'h0010_1ABC, 1, 32'h0020_0ABC, 0);
        chk("swept_asid5", 128'(inst_bus), 0);
        chk("kept_global", 128'(data_bus), 128'({32'h0004_0ABC, 3'd2, 1'b1, 1'b1, 1'b1}));
        cyc(0, 0, 0, 7, 1, 32'h0040_0123, 0, 0, 0);
        chk("kept_asid7", 128'(inst_bus), 128'({32'h000C_0123, 3'd2, 1'b1, 1'b1}));
        cyc(0, 0, 0, 5, 1, 32'h0050_0123, 0, 0, 0);
        chk("busy_write_ignored", 128'(inst_bus), 0);

        // Reset in mid-sweep aborts without a done pulse
        inv_mode = 1'b0; inv_req = 1'b1;
        tick();
        inv_req = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_busy", 128'(busy), 0);
        chk("abort_done", 128'(inv_done), 0);
        chk("abort_probe_idx", 128'(probe_index), 0);
        sweep_wait(bc, dc);
        chk("abort_no_done", 128'(dc), 0);
        cyc(0, 0, 0, 7, 1, 32'h0040_0123, 1, 32'h0020_0ABC, 0);
        chk("abort_inst_ack", 128'(inst_ack), 1);
        chk("abort_inst_miss", 128'(inst_bus), 0);
        chk("abort_data_miss", 128'(data_bus), 0);
        cyc(1, 4, cp(32'h3056, 32'h3016, 32'h0040_0007, 0), 7, 1, 32'h0040_0123, 0, 0, 0);
        chk("wr_same_cycle_miss", 128'(inst_bus), 0);
        cyc(0, 0, 0, 7, 1, 32'h0040_0123, 0, 0, 0);
        chk("wr_next_cycle_hit", 128'(inst_bus), 128'({32'h000C_0123, 3'd2, 1'b1, 1'b1}));

        // Write and sweep request together: sweep sees the new entry
        wr_en = 1'b1; wr_idx = 4'd8; cp0_bus = cp(32'h1056, 32'h1016, 32'h0080_0005, 0);
        inv_req = 1'b1; inv_mode = 1'b1; inv_asid = 8'd5;
        tick();
        wr_en = 1'b0; inv_req = 1'b0;
        sweep_wait(bc, dc);
        chk("wr_inv_busy_cycles", 128'(bc), 17);
        chk("wr_inv_done_pulses", 128'(dc), 1);
        cyc(0, 0, 0, 5, 1, 32'h0080_1123, 0, 0, 0);
        chk("wr_inv_cleared", 128'(inst_bus), 0);
        cyc(0, 0, 0, 7, 1, 32'h0040_0123, 0, 0, 0);
        chk("wr_inv_other_kept", 128'(inst_bus), 128'({32'h000C_0123, 3'd2, 1'b1, 1'b1}));
        rd_idx = 4'd8; tick();
        chk("wr_inv_rd_idx8", rd_bus, cp(32'h1056, 32'h1016, 32'h0080_0005, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlb_gen2.md
TLB_GEN2 -- requirements
Module: tlb_gen2

Interface
REQ-001 SHALL have parameter TLB_NUM, default 16, entry count; power of two, 2..64; IW = clog2(TLB_NUM).
REQ-002 SHALL have parameter ASID_W, default 8, ASID width, 1..8.
REQ-003 SHALL have parameter PAGEMASK_EN, default 1; 0 forces the stored mask to zero, giving fixed 4 KB pages.
REQ-004 SHALL have ports as listed (name direction width meaning):
- clk  in  1  sole clock; rising edge.
- rst  in  1  reset, synchronous, active-high.
- asid_i  in  ASID_W  current ASID.
- inst_req_i  in  1  instruction lookup request.
- inst_vaddr_i  in  32  instruction virtual address.
- inst_ack_o  out  1  instruction result valid.
- inst_bus_o  out  37  {paddr[31:0], c[2:0], v, found}.
- data_req_i  in  1  data lookup request.
- data_vaddr_i  in  32  data virtual address.
- data_ack_o  out  1  data result valid.
- data_bus_o  out  38  {paddr[31:0], c[2:0], d, v, found}.
- wr_en_i  in  1  write entry wr_idx_i.
- wr_idx_i  in  IW  write index.
- cp0_bus_i  in  128  {entrylo1, entrylo0, entryhi, pagemask}; used for both write and probe.
- probe_en_i  in  1  probe request.
- probe_ack_o  out  1  probe result valid.
- probe_index_o  out  32  bit31 = miss, low IW bits = index.
- rd_idx_i  in  IW  read index.
- rd_bus_o  out  128  {entrylo1, entrylo0, entryhi, pagemask} of entry rd_idx_i, registered.
- inv_req_i  in  1  start invalidation sweep.
- inv_mode_i  in  1  0 = all entries, 1 = non-global entries with asid == inv_asid_i.
- inv_asid_i  in  ASID_W  sweep ASID.
- busy_o  out  1  sweep in progress.
- inv_done_o  out  1  one-cycle pulse when the sweep ends.

Function
REQ-005 Each entry SHALL hold: e (entry-valid), vpn2[18:0], mask[11:0], g, asid, and for pages 0/1: pfn[19:0], c, d, v.
REQ-006 A write SHALL set e=1, vpn2=entryhi[31:13], asid=entryhi[ASID_W-1:0], mask=pagemask[24:13], g=lo0[0]&lo1[0], pfnN=loN[25:6], cN=loN[5:3], dN=loN[2], vN=loN[1].
REQ-007 Entry i SHALL match when: e is set; (va[31:13] & ~{7'b0,mask}) == (vpn2 & ~{7'b0,mask}); and (g or asid == asid_i).
REQ-008 Page select SHALL be |(va[24:12] & ({mask,1'b1} ^ {1'b0,mask})); paddr = ((pfn & ~{8'b0,mask}) << 12) | (va & {8'b0,mask,12'hfff}).
REQ-009 Lookup fields from all matching entries SHALL be ORed together; found = OR of matches. On a miss, paddr, c, d and v are 0.
REQ-010 Lookup latency SHALL be 1 cycle: a request at edge N produces ack=1 and a registered bus after edge N; the bus holds its value until the next ack.
REQ-011 Instruction and data lookups SHALL be independent and may complete in the same cycle.
REQ-012 Probe SHALL use the same 1-cycle latency and match entryhi against every entry using the REQ-007 rule with entryhi's ASID. Hit: probe_index_o = index, bit31 = 0. Miss: probe_index_o = 32'h8000_0000. Multiple hits: lowest index wins.
REQ-013 Write-then-read ordering: lookups, probes and reads sampled in the same cycle as a write SHALL see the old contents; requests one cycle later see the new contents.
REQ-014 rd_bus_o SHALL update every cycle from rd_idx_i. Entryhi = {vpn2, 5'b0, zero-extended asid}; lo fields rebuilt with g in bit 0; pagemask = {7'b0, mask, 13'b0}.
REQ-015 Sweep FSM states:
- IDLE: inv_req_i -> SWEEP with counter = 0.
- SWEEP: entry[counter] is evaluated and counter increments each cycle; at counter == TLB_NUM-1 -> DONE.
- DONE: inv_done_o = 1 for one cycle -> IDLE.
REQ-016 In SWEEP, an entry SHALL be cleared (e=0) if inv_mode_i=0, or if g=0 and asid == inv_asid_i; the mode and ASID are latched at the start of the sweep.
REQ-017 busy_o SHALL be 1 in SWEEP and DONE. While busy: lookup and probe requests get ack=1 with found=0 and bus zero; wr_en_i and inv_req_i are ignored.
REQ-018 When wr_en_i and inv_req_i arrive together in IDLE, the write SHALL complete first, and the sweep (starting next cycle) evaluates the written entry.
REQ-019 The sweep SHALL take exactly TLB_NUM+1 cycles from the inv_req_i edge to the inv_done_o pulse.

Reset
REQ-020 On rst=1 at an edge, the block SHALL clear every entry's e bit and all stored fields, enter IDLE, clear the counter, and drive all outputs to 0 (probe_index_o = 0). This includes a reset in mid-sweep, which aborts the sweep with no inv_done_o pulse.

Verification
REQ-021 Write idx3: hi=0x0040_0005, lo0=0x0000_1016, lo1=0x0000_1056, asid_i=5; inst lookup va 0x0040_1ABC -> next cycle ack=1, paddr=0x0004_1ABC, c=2, v=1, found=1.
REQ-022 Pagemask 0x0000_6000 (16 KB) at idx0 with vpn2 for va 0x0100_0000, lo1 pfn=0x200; data lookup va 0x0100_7123 -> paddr 0x0020_3123, page 1 selected.
REQ-023 Probe entryhi 0x0040_0006 against the REQ-021 entry (non-global, asid 5) -> probe_index_o = 0x8000_0000. After rewriting with g=1 -> probe_index_o = 3.
REQ-024 TLB_NUM=16 sweep with mode 1, ASID 5, over entries {asid5 non-global, asid5 global, asid7} -> busy_o for 17 cycles, inv_done_o pulse; only the first entry misses afterwards. A lookup during busy -> ack=1, found=0.
REQ-025 Assert rst at sweep cycle 4 -> busy_o=0 next cycle, all lookups miss, no inv_done_o; a write plus lookup in the same cycle -> miss, and the lookup one cycle later hits.
